// File: rtl/ysyx_23060240_csr_file_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encoding,
// trap cause codes and mstatus/mie bit positions.
package ysyx_23060240_csr_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    // Winning event of a cycle; EV_NONE leaves the CSR instruction in charge.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_IRQ_EXT,
        EV_IRQ_TMR,
        EV_ECALL,
        EV_EBREAK,
        EV_MRET
    } csr_ev_e;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam logic [3:0] CAUSE_ECALL   = 4'd11;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_IRQ_EXT = 4'd11;
    localparam logic [3:0] CAUSE_IRQ_TMR = 4'd7;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Reserved mtvec modes collapse to direct.
    function automatic logic [1:0] mtvec_mode_warl(input logic [1:0] mode);
        return (mode == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT;
    endfunction

endpackage

// File: rtl/ysyx_23060240_csr_file_if.sv
// CSR access bus between the execute stage (master) and the CSR file (slave).
interface ysyx_23060240_csr_file_if #(
    parameter int XLEN = 32
);
    logic            csr_en;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_en, csr_op, csr_addr, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_en, csr_op, csr_addr, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/ysyx_23060240_csr_cnt64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to one half replaces that half's increment; the other half keeps
// its value and receives no carry from the written half.
module ysyx_23060240_csr_cnt64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [63:0] wdata,
    output logic [63:0] cnt
);
    logic [63:0] cnt_q;
    logic [63:0] cnt_inc;

    assign cnt_inc = cnt_q + 64'(inc_en);
    assign cnt     = cnt_q;

    // Count, or take the written half(s) in place of the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q[31:0]  <= wr_lo ? wdata[31:0] : cnt_inc[31:0];
            cnt_q[63:32] <= wr_hi ? wdata[63:32] :
                            (wr_lo ? cnt_q[63:32] : cnt_inc[63:32]);
        end
    end
endmodule

// File: rtl/ysyx_23060240_csr_file.sv
// Machine-mode CSR file: CSR read/modify/write, trap entry, mret and the
// cycle/instret counters. Traps and mret redirect fetch in the same cycle.
module ysyx_23060240_csr_file
    import ysyx_23060240_csr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter int              HAS_CNT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [XLEN-1:0]         pc,
    ysyx_23060240_csr_file_if.slave csr_bus,
    input  logic                    ecall,
    input  logic                    ebreak,
    input  logic                    mret,
    input  logic                    retire,
    input  logic                    irq_tmr,
    input  logic                    irq_ext,
    output logic                    redirect,
    output logic [XLEN-1:0]         redirect_pc
);
    logic            mst_mie, mst_mpie;
    logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0]     mcycle, minstret;

    logic [XLEN-1:0] misa_val, old_val, new_val, cause_val, trap_base;
    logic            known, read_only, do_write, illegal, csr_wr;
    logic            irq_ext_take, irq_tmr_take, trap, is_irq;
    logic [3:0]      cause_code;
    csr_ev_e         ev;
    csr_op_e         op;
    logic [63:0]     nv64, cnt_wdata;
    logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

    assign op = csr_op_e'(csr_bus.csr_op);

    // Constant misa: MXL for the configured width plus the I extension.
    always_comb begin
        misa_val = '0;
        misa_val[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'b10 : 2'b01;
        misa_val[8] = 1'b1;
    end

    // Address decode: current value, existence and read-only attribute.
    always_comb begin
        known     = 1'b1;
        read_only = 1'b0;
        old_val   = '0;
        case (csr_bus.csr_addr)
            ADDR_MSTATUS: begin
                old_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                old_val[MSTATUS_MPIE] = mst_mpie;
                old_val[MSTATUS_MIE]  = mst_mie;
            end
            ADDR_MISA: begin
                old_val   = misa_val;
                read_only = 1'b1;
            end
            ADDR_MIE:      old_val = mie_q;
            ADDR_MTVEC:    old_val = mtvec_q;
            ADDR_MSCRATCH: old_val = mscratch_q;
            ADDR_MEPC:     old_val = mepc_q;
            ADDR_MCAUSE:   old_val = mcause_q;
            ADDR_MIP: begin
                old_val[MIE_MEIE] = irq_ext;
                old_val[MIE_MTIE] = irq_tmr;
                read_only = 1'b1;
            end
            ADDR_MHARTID:  read_only = 1'b1;
            ADDR_MCYCLE: begin
                known   = (HAS_CNT != 0);
                old_val = mcycle[XLEN-1:0];
            end
            ADDR_MINSTRET: begin
                known   = (HAS_CNT != 0);
                old_val = minstret[XLEN-1:0];
            end
            ADDR_MCYCLEH: begin
                known   = (HAS_CNT != 0) && (XLEN == 32);
                old_val = mcycle[63:64-XLEN];
            end
            ADDR_MINSTRETH: begin
                known   = (HAS_CNT != 0) && (XLEN == 32);
                old_val = minstret[63:64-XLEN];
            end
            default: known = 1'b0;
        endcase
    end

    // Set/clear with a zero mask is a pure read, so it never trips read-only.
    assign do_write = (op == OP_RW) || ((op != OP_NONE) && (csr_bus.csr_wdata != '0));
    assign illegal  = csr_bus.csr_en && (!known || (read_only && do_write));

    // Read-modify-write value.
    always_comb begin
        case (op)
            OP_RW:   new_val = csr_bus.csr_wdata;
            OP_RS:   new_val = old_val | csr_bus.csr_wdata;
            OP_RC:   new_val = old_val & ~csr_bus.csr_wdata;
            default: new_val = old_val;
        endcase
    end

    // Pick the single winning event; everything lower in priority is dropped.
    always_comb begin
        irq_ext_take = mst_mie & mie_q[MIE_MEIE] & irq_ext;
        irq_tmr_take = mst_mie & mie_q[MIE_MTIE] & irq_tmr;
        if (irq_ext_take)      ev = EV_IRQ_EXT;
        else if (irq_tmr_take) ev = EV_IRQ_TMR;
        else if (ecall)        ev = EV_ECALL;
        else if (ebreak)       ev = EV_EBREAK;
        else if (mret)         ev = EV_MRET;
        else                   ev = EV_NONE;
    end

    // Cause code and mcause image for the winning trap.
    always_comb begin
        is_irq     = 1'b0;
        cause_code = 4'd0;
        trap       = 1'b1;
        case (ev)
            EV_IRQ_EXT: begin is_irq = 1'b1; cause_code = CAUSE_IRQ_EXT; end
            EV_IRQ_TMR: begin is_irq = 1'b1; cause_code = CAUSE_IRQ_TMR; end
            EV_ECALL:   cause_code = CAUSE_ECALL;
            EV_EBREAK:  cause_code = CAUSE_EBREAK;
            default:    trap = 1'b0;
        endcase
        cause_val = '0;
        cause_val[XLEN-1] = is_irq;
        cause_val[3:0]    = cause_code;
    end

    assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};

    // Fetch redirect; silent while in reset.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        if (!rst) begin
            if (trap) begin
                redirect    = 1'b1;
                redirect_pc = trap_base;
                if (is_irq && (mtvec_q[1:0] == MTVEC_VECTORED))
                    redirect_pc = trap_base + XLEN'({cause_code, 2'b00});
            end else if (ev == EV_MRET) begin
                redirect    = 1'b1;
                redirect_pc = mepc_q;
            end
        end
    end

    assign csr_wr = csr_bus.csr_en && do_write && !illegal && (ev == EV_NONE);

    assign csr_bus.csr_rdata   = (!rst && csr_bus.csr_en && !illegal) ? old_val : '0;
    assign csr_bus.csr_illegal = !rst && illegal;

    // Counter half-writes; on XLEN=64 the low address covers the whole counter.
    always_comb begin
        nv64      = 64'(new_val);
        cnt_wdata = {(XLEN == 64) ? nv64[63:32] : nv64[31:0], nv64[31:0]};
        cyc_wr_lo = csr_wr && (csr_bus.csr_addr == ADDR_MCYCLE);
        cyc_wr_hi = csr_wr && (((csr_bus.csr_addr == ADDR_MCYCLE) && (XLEN == 64)) ||
                               (csr_bus.csr_addr == ADDR_MCYCLEH));
        ins_wr_lo = csr_wr && (csr_bus.csr_addr == ADDR_MINSTRET);
        ins_wr_hi = csr_wr && (((csr_bus.csr_addr == ADDR_MINSTRET) && (XLEN == 64)) ||
                               (csr_bus.csr_addr == ADDR_MINSTRETH));
    end

    ysyx_23060240_csr_cnt64 u_mcycle (
        .clk    (clk),
        .rst    (rst),
        .inc_en (1'b1),
        .wr_lo  (cyc_wr_lo),
        .wr_hi  (cyc_wr_hi),
        .wdata  (cnt_wdata),
        .cnt    (mcycle)
    );

    ysyx_23060240_csr_cnt64 u_minstret (
        .clk    (clk),
        .rst    (rst),
        .inc_en (retire && !trap),
        .wr_lo  (ins_wr_lo),
        .wr_hi  (ins_wr_hi),
        .wdata  (cnt_wdata),
        .cnt    (minstret)
    );

    // Architectural state update: trap entry, mret, else the CSR write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (trap) begin
            mepc_q   <= pc & ~XLEN'(3);
            mcause_q <= cause_val;
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
        end else if (ev == EV_MRET) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
        end else if (csr_wr) begin
            case (csr_bus.csr_addr)
                ADDR_MSTATUS: begin
                    mst_mie  <= new_val[MSTATUS_MIE];
                    mst_mpie <= new_val[MSTATUS_MPIE];
                end
                ADDR_MIE:      mie_q      <= new_val;
                ADDR_MTVEC:    mtvec_q    <= {new_val[XLEN-1:2], mtvec_mode_warl(new_val[1:0])};
                ADDR_MSCRATCH: mscratch_q <= new_val;
                ADDR_MEPC:     mepc_q     <= new_val & ~XLEN'(3);
                ADDR_MCAUSE:   mcause_q   <= new_val;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060240_csr_file.sv
// Directed bench for the CSR file: expectations are queued when a step is
// driven and checked against the outputs at the falling edge of that cycle.
module tb_ysyx_23060240_csr_file;
    localparam int          XLEN      = 32;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0040;

    typedef enum {S_RDATA, S_ILL, S_RDR, S_RPC} sig_e;
    typedef struct {
        sig_e        sig;
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ecall, ebreak, mret, retire, irq_tmr, irq_ext;
    logic        redirect;
    logic [31:0] redirect_pc;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ysyx_23060240_csr_file_if #(.XLEN(XLEN)) bus ();

    ysyx_23060240_csr_file #(
        .XLEN      (XLEN),
        .MTVEC_RST (MTVEC_RST),
        .HAS_CNT   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .csr_bus     (bus),
        .ecall       (ecall),
        .ebreak      (ebreak),
        .mret        (mret),
        .retire      (retire),
        .irq_tmr     (irq_tmr),
        .irq_ext     (irq_ext),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        bus.csr_en    = 1'b0;
        bus.csr_op    = 2'b00;
        bus.csr_addr  = 12'h000;
        bus.csr_wdata = 32'h0;
        ecall = 1'b0; ebreak = 1'b0; mret = 1'b0; retire = 1'b0;
        irq_tmr = 1'b0; irq_ext = 1'b0;
    endtask

    task automatic push(input sig_e sig, input string tag, input logic [31:0] val);
        exp_t e;
        e.sig = sig;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sig)
                S_RDATA: obs = bus.csr_rdata;
                S_ILL:   obs = {31'b0, bus.csr_illegal};
                S_RDR:   obs = {31'b0, redirect};
                default: obs = redirect_pc;
            endcase
            n_tests++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Finish the current cycle: check at the falling edge, commit on the rising edge.
    task automatic cyc();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic acc(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        bus.csr_en    = 1'b1;
        bus.csr_op    = op;
        bus.csr_addr  = addr;
        bus.csr_wdata = wdata;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        acc(2'b00, addr, 32'h0);
        push(S_RDATA, tag, exp);
        push(S_ILL, {tag, "_ill"}, 32'h0);
        cyc();
    endtask

    task automatic wr(input string tag, input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        acc(op, addr, wdata);
        push(S_ILL, tag, 32'h0);
        cyc();
    endtask

    task automatic redir(input string tag, input logic rdr, input logic [31:0] rpc);
        push(S_RDR, {tag, "_redirect"}, {31'b0, rdr});
        push(S_RPC, {tag, "_pc"}, rpc);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        pc  = 32'h0;

        // Outputs stay quiet while in reset, even with a read and an ecall.
        acc(2'b00, 12'h300, 32'h0);
        ecall = 1'b1;
        pc    = 32'h0000_0100;
        push(S_RDATA, "rst_rdata", 32'h0);
        push(S_ILL, "rst_illegal", 32'h0);
        redir("rst_ecall", 1'b0, 32'h0);
        cyc();
        rst = 1'b0;

        rd("mstatus_rst", 12'h300, 32'h0000_1800);
        rd("mtvec_rst",   12'h305, MTVEC_RST);
        rd("mhartid",     12'hF14, 32'h0);
        rd("misa",        12'h301, 32'h4000_0100);
        rd("mepc_rst",    12'h341, 32'h0);

        // mtvec WARL mode.
        wr("wr_mtvec_m2", 2'b01, 12'h305, 32'h8000_0102);
        rd("mtvec_warl",  12'h305, 32'h8000_0100);
        wr("wr_mtvec",    2'b01, 12'h305, 32'h8000_0101);
        rd("mtvec_vec",   12'h305, 32'h8000_0101);

        // mstatus: only MIE/MPIE writable, MPP pinned.
        wr("rs_mstatus",  2'b10, 12'h300, 32'h0000_0008);
        rd("mstatus_mie", 12'h300, 32'h0000_1808);
        wr("rw_mstatus",  2'b01, 12'h300, 32'hFFFF_FFFF);
        rd("mstatus_all", 12'h300, 32'h0000_1888);
        wr("rc_mstatus",  2'b11, 12'h300, 32'h0000_0080);
        rd("mstatus_rc",  12'h300, 32'h0000_1808);

        // ecall: exception goes to mtvec base even in vectored mode.
        ecall = 1'b1;
        pc    = 32'h8000_0010;
        redir("ecall", 1'b1, 32'h8000_0100);
        cyc();
        rd("ecall_mepc",    12'h341, 32'h8000_0010);
        rd("ecall_mcause",  12'h342, 32'd11);
        rd("ecall_mstatus", 12'h300, 32'h0000_1880);

        // mret restores MIE from MPIE.
        mret = 1'b1;
        redir("mret", 1'b1, 32'h8000_0010);
        cyc();
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // Timer interrupt beats ecall, vectored target.
        wr("wr_mtvec2", 2'b01, 12'h305, 32'h8000_0001);
        wr("rs_mtie",   2'b10, 12'h304, 32'h0000_0080);
        irq_tmr = 1'b1;
        ecall   = 1'b1;
        pc      = 32'h8000_0200;
        redir("irq_tmr", 1'b1, 32'h8000_001C);
        cyc();
        rd("tmr_mcause",  12'h342, 32'h8000_0007);
        rd("tmr_mepc",    12'h341, 32'h8000_0200);
        rd("tmr_mstatus", 12'h300, 32'h0000_1880);

        // mret beats a same-cycle CSR write.
        mret = 1'b1;
        acc(2'b01, 12'h340, 32'h0000_1234);
        redir("mret_vs_csr", 1'b1, 32'h8000_0200);
        cyc();
        rd("mscratch_lost", 12'h340, 32'h0);

        // External interrupt beats timer.
        wr("rs_meie", 2'b10, 12'h304, 32'h0000_0800);
        irq_ext = 1'b1;
        irq_tmr = 1'b1;
        pc      = 32'h8000_0300;
        redir("irq_ext", 1'b1, 32'h8000_002C);
        cyc();
        rd("ext_mcause", 12'h342, 32'h8000_000B);

        // mip mirrors inputs; MIE=0 now masks the pending timer.
        irq_tmr = 1'b1;
        acc(2'b00, 12'h344, 32'h0);
        push(S_RDATA, "mip", 32'h0000_0080);
        redir("irq_masked", 1'b0, 32'h0);
        cyc();

        // Read-only and unknown addresses.
        irq_tmr = 1'b1;
        acc(2'b01, 12'h344, 32'h0000_0FFF);
        push(S_ILL, "mip_rw_ill", 32'h1);
        push(S_RDATA, "mip_rw_rdata", 32'h0);
        cyc();
        irq_tmr = 1'b1;
        acc(2'b10, 12'h344, 32'h0);
        push(S_ILL, "mip_rs0_ill", 32'h0);
        push(S_RDATA, "mip_rs0_rdata", 32'h0000_0080);
        cyc();
        acc(2'b00, 12'h7C0, 32'h0);
        push(S_ILL, "unknown_ill", 32'h1);
        push(S_RDATA, "unknown_rdata", 32'h0);
        cyc();
        rd("mie_kept", 12'h304, 32'h0000_0880);

        // mcycle wraps 2^64-1 -> 0.
        wr("wr_mcycleh", 2'b01, 12'hB80, 32'hFFFF_FFFF);
        wr("wr_mcycle",  2'b01, 12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_max", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_wrap", 12'hB80, 32'h0);
        rd("mcycle_after", 12'hB00, 32'h1);

        // minstret: write replaces increment, trap suppresses it.
        retire = 1'b1;
        wr("wr_minstret", 2'b01, 12'hB02, 32'h0000_0010);
        rd("minstret_wr", 12'hB02, 32'h0000_0010);
        retire = 1'b1;
        cyc();
        retire = 1'b1;
        cyc();
        retire = 1'b1;
        ecall  = 1'b1;
        pc     = 32'h8000_0500;
        redir("ecall_retire", 1'b1, 32'h8000_0000);
        cyc();
        rd("minstret", 12'hB02, 32'h0000_0012);
        rd("minstreth", 12'hB82, 32'h0);

        ebreak = 1'b1;
        pc     = 32'h8000_0600;
        redir("ebreak", 1'b1, 32'h8000_0000);
        cyc();
        rd("ebreak_mcause", 12'h342, 32'd3);

        // Reset arriving mid-ecall discards the trap.
        ecall = 1'b1;
        pc    = 32'h8000_0444;
        #2 rst = 1'b1;
        redir("rst_mid_ecall", 1'b0, 32'h0);
        cyc();
        rst = 1'b0;

        // First edge after reset release takes an event.
        acc(2'b00, 12'h341, 32'h0);
        ecall = 1'b1;
        pc    = 32'h8000_0480;
        push(S_RDATA, "mepc_after_rst", 32'h0);
        redir("first_ecall", 1'b1, MTVEC_RST);
        cyc();
        rd("first_mepc",    12'h341, 32'h8000_0480);
        rd("first_mcause",  12'h342, 32'd11);
        rd("first_mstatus", 12'h300, 32'h0000_1800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_23060240_csr_file.md
YSYX_23060240_CSR_FILE -- requirements
Module: ysyx_23060240_csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, machine word width (32 or 64).
REQ-002 SHALL have parameter MTVEC_RST, default 0, mtvec reset value.
REQ-003 SHALL have parameter HAS_CNT, default 1, mcycle/minstret present (0: addresses illegal).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pc  input  XLEN  PC of the instruction in execute.
REQ-007 SHALL have port csr_en  input  1  CSR instruction valid this cycle.
REQ-008 SHALL have port csr_op  input  2  00 none, 01 RW, 10 RS (set), 11 RC (clear).
REQ-009 SHALL have port csr_addr  input  12  CSR address.
REQ-010 SHALL have port csr_wdata  input  XLEN  rs1/zimm operand.
REQ-011 SHALL have port csr_rdata  output  XLEN  old CSR value, combinational.
REQ-012 SHALL have port csr_illegal  output  1  unknown address or write to read-only CSR.
REQ-013 SHALL have ports ecall, ebreak, mret  input  1 each  instruction events.
REQ-014 SHALL have port retire  input  1  one instruction retired this cycle.
REQ-015 SHALL have ports irq_tmr, irq_ext  input  1 each  level interrupt requests.
REQ-016 SHALL have port redirect  output  1  fetch redirect this cycle (trap or mret).
REQ-017 SHALL have port redirect_pc  output  XLEN  target of redirect.

Function
REQ-018 SHALL implement mstatus(0x300), misa(0x301, RO), mie(0x304), mtvec(0x305), mscratch(0x340), mepc(0x341), mcause(0x342), mip(0x344, RO), mhartid(0xF14, RO, 0), mcycle(0xB00), minstret(0xB02); XLEN=32 adds mcycleh(0xB80), minstreth(0xB82).
REQ-019 SHALL compute new = wdata (RW), old|wdata (RS), old&~wdata (RC); write at clock edge when csr_en and not illegal; RS/RC with wdata=0 SHALL write nothing and never flag illegal on RO CSRs.
REQ-020 SHALL hold mstatus.MPP at 2'b11; only MIE(bit3), MPIE(bit7) writable; other bits read 0.
REQ-021 SHALL treat mtvec[1:0] as WARL: 0 direct, 1 vectored; writes of 2/3 store 0; mepc[1:0] SHALL read 0.
REQ-022 SHALL assert irq_pending when mstatus.MIE and ((mie.MEIE&irq_ext)|(mie.MTIE&irq_tmr)); mip.MEIP/MTIP mirror inputs.
REQ-023 SHALL resolve same-cycle events by priority: interrupt (ext > timer) > ecall > ebreak > mret > CSR write; losers have no effect.
REQ-024 On trap SHALL, at the edge: mepc<=pc, mcause<=code (ecall 11, ebreak 3, ext irq MSB|11, timer irq MSB|7), MPIE<=MIE, MIE<=0; redirect=1 same cycle.
REQ-025 Trap redirect_pc SHALL be mtvec.BASE, or BASE+4*cause for interrupts in vectored mode.
REQ-026 On mret SHALL set MIE<=MPIE, MPIE<=1, redirect=1, redirect_pc=mepc.
REQ-027 mcycle SHALL be 64-bit, +1 every cycle, wrap 2^64-1 -> 0; a CSR write to either half that cycle SHALL replace the increment for that half's written value (other half unchanged, no carry).
REQ-028 minstret SHALL be 64-bit, +1 when retire and no trap this cycle; same write/wrap rules as mcycle.
REQ-029 csr_rdata SHALL be 0 when csr_en=0 or illegal; redirect_pc SHALL be 0 when redirect=0.

Reset
REQ-030 While rst: mstatus=0x1800, mtvec=MTVEC_RST, mie/mscratch/mepc/mcause=0, counters=0; all outputs 0.
REQ-031 Reset asserted mid-trap SHALL discard the trap; first event SHALL be accepted on the first edge after rst falls.

Structure
REQ-032 Package ysyx_23060240_csr_pkg SHALL hold CSR address constants, csr_op encoding, cause codes, mstatus bit indices.
REQ-033 Sub-module ysyx_23060240_csr_cnt64 SHALL implement one 64-bit counter with increment enable and lo/hi split write; instantiated twice.

Verification
REQ-034 Reset release, read 0x300 -> 0x00001800; read 0x305 -> MTVEC_RST; read 0xF14 -> 0.
REQ-035 RW mtvec=0x80000101 then ecall at pc=0x80000010 -> redirect_pc=0x80000100, mepc=0x80000010, mcause=11, MIE 1->0, MPIE=1.
REQ-036 mtvec=0x80000001, MIE=1, mie.MTIE=1, irq_tmr=1 plus ecall same cycle -> interrupt wins, redirect_pc=0x8000001C, mcause=0x80000007.
REQ-037 mret after REQ-035 -> redirect_pc=0x80000010, MIE=1, MPIE=1.
REQ-038 XLEN=32, write mcycle=0xFFFFFFFF, mcycleh=0xFFFFFFFF -> after one cycle both read 0; CSR write on RO 0x344 with RW -> csr_illegal=1, no state change.
REQ-039 Assert rst during an ecall cycle -> mepc stays 0, redirect=0.
